mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port (F_*) and the data-access port (M_*).
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   F_Req/F_Addr           : fetch request and byte address
//   M_Req/M_Addr/M_WE/M_WData : data request, byte address, byte enables
//                            (0000 = read), write data
//   Flush                  : M-stage exception redirect, kills grants for a cycle
//   mem_addr/mem_we/mem_wdata/mem_rdata : RAM port, read data one cycle late
//   F_Gnt/F_RValid/F_RData : fetch grant and read return
//   M_Gnt/M_RValid/M_RData : data grant and read return
// Data accesses win contention, but a fetch that has lost twice in a row
// wins the third cycle so the front end cannot starve.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_Req,
  input  logic [31:0] F_Addr,
  input  logic        M_Req,
  input  logic [31:0] M_Addr,
  input  logic [3:0]  M_WE,
  input  logic [31:0] M_WData,
  input  logic        Flush,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        F_Gnt,
  output logic        F_RValid,
  output logic [31:0] F_RData,
  output logic        M_Gnt,
  output logic        M_RValid,
  output logic [31:0] M_RData
);

  typedef enum logic [1:0] {IDLE, F_RD, M_RD, M_WR} state_t;

  state_t     state, state_nxt;
  logic [1:0] starve, starve_nxt;
  logic       f_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      starve <= 2'd0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    F_Gnt      = 1'b0;
    M_Gnt      = 1'b0;
    mem_addr   = 32'd0;
    mem_we     = 4'd0;
    mem_wdata  = 32'd0;
    F_RValid   = 1'b0;
    F_RData    = 32'd0;
    M_RValid   = 1'b0;
    M_RData    = 32'd0;
    state_nxt  = IDLE;
    starve_nxt = 2'd0;

    // Fetch takes the port when alone, or when it has been starved twice.
    f_wins = F_Req && (!M_Req || starve == 2'd2);

    if (!reset && !Flush) begin
      F_Gnt = f_wins;
      M_Gnt = M_Req && !f_wins;
    end

    if (F_Gnt) begin
      mem_addr  = {F_Addr[31:2], 2'b00};
      state_nxt = F_RD;
    end else if (M_Gnt) begin
      mem_addr  = {M_Addr[31:2], 2'b00};
      mem_we    = M_WE;
      mem_wdata = M_WData;
      state_nxt = (M_WE == 4'd0) ? M_RD : M_WR;
    end

    // Counts consecutive fetch losses; saturates at 2 (a third loss cannot
    // happen since starve==2 hands the port to fetch).
    if (M_Gnt && F_Req)
      starve_nxt = (starve == 2'd2) ? 2'd2 : starve + 2'd1;

    // A reset cycle drops any return from a read launched before it; Flush
    // only drops a fetch return, a load that already issued still completes.
    if (!reset) begin
      case (state)
        F_RD: if (!Flush) begin
          F_RValid = 1'b1;
          F_RData  = mem_rdata;
        end
        M_RD: begin
          M_RValid = 1'b1;
          M_RData  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, F_Req, M_Req, Flush;
  logic [31:0] F_Addr, M_Addr, M_WData, mem_rdata;
  logic [3:0]  M_WE;
  logic [31:0] mem_addr, mem_wdata, F_RData, M_RData;
  logic [3:0]  mem_we;
  logic        F_Gnt, F_RValid, M_Gnt, M_RValid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .F_Req(F_Req), .F_Addr(F_Addr),
    .M_Req(M_Req), .M_Addr(M_Addr), .M_WE(M_WE), .M_WData(M_WData),
    .Flush(Flush),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .F_Gnt(F_Gnt), .F_RValid(F_RValid), .F_RData(F_RData),
    .M_Gnt(M_Gnt), .M_RValid(M_RValid), .M_RData(M_RData)
  );

  typedef struct {
    logic        rst, freq, mreq, flush;
    logic [31:0] faddr, maddr, mwdata, rdata;
    logic [3:0]  mwe;
    logic        fg, mg, fv, mv;
    logic [31:0] addr, wdata, fd, md;
    logic [3:0]  we;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic rst, logic freq, logic [31:0] faddr, logic mreq, logic [31:0] maddr,
    logic [3:0] mwe, logic [31:0] mwdata, logic flush, logic [31:0] rdata,
    logic fg, logic mg, logic [31:0] addr, logic [3:0] we, logic [31:0] wdata,
    logic fv, logic [31:0] fd, logic mv, logic [31:0] md);
    vec_t v;
    v.rst = rst; v.freq = freq; v.faddr = faddr; v.mreq = mreq; v.maddr = maddr;
    v.mwe = mwe; v.mwdata = mwdata; v.flush = flush; v.rdata = rdata;
    v.fg = fg; v.mg = mg; v.addr = addr; v.we = we; v.wdata = wdata;
    v.fv = fv; v.fd = fd; v.mv = mv; v.md = md;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; F_Req = v.freq; F_Addr = v.faddr; M_Req = v.mreq;
    M_Addr = v.maddr; M_WE = v.mwe; M_WData = v.mwdata; Flush = v.flush;
    mem_rdata = v.rdata;
  endtask

  // Inputs change at negedge; outputs are sampled 1 time unit later, well
  // before the next rising edge commits the cycle.
  task automatic apply(input vec_t v, input int row);
    @(negedge clk);
    drive(v);
    #1;
    chk("F_Gnt",     row, {31'd0, F_Gnt},    {31'd0, v.fg});
    chk("M_Gnt",     row, {31'd0, M_Gnt},    {31'd0, v.mg});
    chk("mem_addr",  row, mem_addr,          v.addr);
    chk("mem_we",    row, {28'd0, mem_we},   {28'd0, v.we});
    chk("mem_wdata", row, mem_wdata,         v.wdata);
    chk("F_RValid",  row, {31'd0, F_RValid}, {31'd0, v.fv});
    chk("F_RData",   row, F_RData,           v.fd);
    chk("M_RValid",  row, {31'd0, M_RValid}, {31'd0, v.mv});
    chk("M_RData",   row, M_RData,           v.md);
  endtask

  initial begin
    //        rst F  F_Addr      M  M_Addr      WE    WData         Fl rdata
    //        -> Fg Mg mem_addr  we    wdata       Fv F_RData     Mv M_RData
    // reset state
    vt.push_back(mk(1,1,32'h3000,0,32'h0,4'h0,32'h0,0,32'h0,
                    0,0,32'h0,4'h0,32'h0,0,32'h0,0,32'h0));
    vt.push_back(mk(1,1,32'h3000,1,32'h10,4'hF,32'h1,0,32'h5,
                    0,0,32'h0,4'h0,32'h0,0,32'h0,0,32'h0));
    // fetch only: grant on first cycle out of reset, then back-to-back returns
    vt.push_back(mk(0,1,32'h3000,0,32'h0,4'h0,32'h0,0,32'h24010001,
                    1,0,32'h3000,4'h0,32'h0,0,32'h0,0,32'h0));
    vt.push_back(mk(0,1,32'h3000,0,32'h0,4'h0,32'h0,0,32'h24010001,
                    1,0,32'h3000,4'h0,32'h0,1,32'h24010001,0,32'h0));
    vt.push_back(mk(0,1,32'h3000,0,32'h0,4'h0,32'h0,0,32'h24010001,
                    1,0,32'h3000,4'h0,32'h0,1,32'h24010001,0,32'h0));
    // contention: M, M, F, M
    vt.push_back(mk(0,1,32'h3004,1,32'h100,4'h0,32'h0,0,32'h11111111,
                    0,1,32'h100,4'h0,32'h0,1,32'h11111111,0,32'h0));
    vt.push_back(mk(0,1,32'h3004,1,32'h100,4'h0,32'h0,0,32'h22222222,
                    0,1,32'h100,4'h0,32'h0,0,32'h0,1,32'h22222222));
    vt.push_back(mk(0,1,32'h3004,1,32'h100,4'h0,32'h0,0,32'h33333333,
                    1,0,32'h3004,4'h0,32'h0,0,32'h0,1,32'h33333333));
    vt.push_back(mk(0,1,32'h3004,1,32'h100,4'h0,32'h0,0,32'h44444444,
                    0,1,32'h100,4'h0,32'h0,1,32'h44444444,0,32'h0));
    // store to unaligned address, then M_WR cycle returns nothing
    vt.push_back(mk(0,0,32'h0,1,32'h7,4'hF,32'hDEADBEEF,0,32'h55555555,
                    0,1,32'h4,4'hF,32'hDEADBEEF,0,32'h0,1,32'h55555555));
    vt.push_back(mk(0,0,32'h0,0,32'h0,4'h0,32'h0,0,32'h66666666,
                    0,0,32'h0,4'h0,32'h0,0,32'h0,0,32'h0));
    // lone load with unaligned address
    vt.push_back(mk(0,0,32'h0,1,32'h203,4'h0,32'h0,0,32'h0,
                    0,1,32'h200,4'h0,32'h0,0,32'h0,0,32'h0));
    vt.push_back(mk(0,0,32'h0,0,32'h0,4'h0,32'h0,0,32'h77777777,
                    0,0,32'h0,4'h0,32'h0,0,32'h0,1,32'h77777777));
    // flush kills a fetch return and both grants, grants resume after
    vt.push_back(mk(0,1,32'h40,0,32'h0,4'h0,32'h0,0,32'h0,
                    1,0,32'h40,4'h0,32'h0,0,32'h0,0,32'h0));
    vt.push_back(mk(0,1,32'h40,1,32'h80,4'hF,32'h12345678,1,32'h88888888,
                    0,0,32'h0,4'h0,32'h0,0,32'h0,0,32'h0));
    vt.push_back(mk(0,1,32'h40,1,32'h80,4'hF,32'h12345678,0,32'h0,
                    0,1,32'h80,4'hF,32'h12345678,0,32'h0,0,32'h0));
    // starve reaches 2, flush clears it; load return survives the flush
    vt.push_back(mk(0,1,32'h40,1,32'h80,4'h0,32'h0,0,32'h0,
                    0,1,32'h80,4'h0,32'h0,0,32'h0,0,32'h0));
    vt.push_back(mk(0,1,32'h40,1,32'h80,4'h0,32'h0,1,32'h99999999,
                    0,0,32'h0,4'h0,32'h0,0,32'h0,1,32'h99999999));
    vt.push_back(mk(0,1,32'h40,1,32'h80,4'h0,32'h0,0,32'h0,
                    0,1,32'h80,4'h0,32'h0,0,32'h0,0,32'h0));

    drive(vt[0]);
    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Hand sequence: reset lands while a load is in flight (state is M_RD
    // from the last table row); the return must vanish.
    begin
      vec_t v;
      v = mk(1,1,32'h40,1,32'h80,4'h0,32'h0,0,32'hABCDABCD,
             0,0,32'h0,4'h0,32'h0,0,32'h0,0,32'h0);
      apply(v, 100);
      // first cycle after reset: fresh grant, nothing returning
      v = mk(0,0,32'h0,1,32'h84,4'h0,32'h0,0,32'hABCDABCD,
             0,1,32'h84,4'h0,32'h0,0,32'h0,0,32'h0);
      apply(v, 101);
      v = mk(0,0,32'h0,0,32'h0,4'h0,32'h0,0,32'hCAFEF00D,
             0,0,32'h0,4'h0,32'h0,0,32'h0,1,32'hCAFEF00D);
      apply(v, 102);
    end

    // Hand sequence: fetch flushed on the very cycle its data returns while
    // a store is also pending; store must not reach the RAM during Flush.
    begin
      vec_t v;
      v = mk(0,1,32'h1000,0,32'h0,4'h0,32'h0,0,32'h0,
             1,0,32'h1000,4'h0,32'h0,0,32'h0,0,32'h0);
      apply(v, 200);
      v = mk(0,1,32'h1004,1,32'h2002,4'h3,32'h0000BEEF,1,32'h13579BDF,
             0,0,32'h0,4'h0,32'h0,0,32'h0,0,32'h0);
      apply(v, 201);
      v = mk(0,1,32'h1004,1,32'h2002,4'h3,32'h0000BEEF,0,32'h0,
             0,1,32'h2000,4'h3,32'h0000BEEF,0,32'h0,0,32'h0);
      apply(v, 202);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
